// File: rtl/decode_issue_ctrl_pkg.sv
// Shared definitions for the decode/issue slice: FSM encoding, instruction
// type codes used by the decoder, and the decoder's register-field bundle.
package decode_issue_ctrl_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned RIDX_W = 5;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    typedef enum logic [2:0] {
        ITYPE_R = 3'd0,
        ITYPE_I = 3'd1,
        ITYPE_S = 3'd2,
        ITYPE_B = 3'd3,
        ITYPE_U = 3'd4,
        ITYPE_J = 3'd5
    } itype_e;

    // Register usage of the head instruction as reported by the decoder.
    typedef struct packed {
        logic [RIDX_W-1:0] rd;
        logic [RIDX_W-1:0] rs1;
        logic [RIDX_W-1:0] rs2;
        logic              wen;
    } dec_regs_t;

endpackage

// File: rtl/decode_issue_ctrl_scoreboard.sv
// Pending-write scoreboard: one busy bit per architectural register, with a
// same-cycle writeback bypass on every read port. Register 0 is never busy.
module decode_issue_ctrl_scoreboard
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned NREG = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_set_valid,
    input  logic [RIDX_W-1:0] i_set_idx,
    input  logic              i_clr_valid,
    input  logic [RIDX_W-1:0] i_clr_idx,
    input  logic [RIDX_W-1:0] i_rs1_idx,
    input  logic [RIDX_W-1:0] i_rs2_idx,
    input  logic [RIDX_W-1:0] i_rd_idx,
    output logic              o_rs1_busy,
    output logic              o_rs2_busy,
    output logic              o_rd_busy,
    output logic [NREG-1:0]   o_busy
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] busy_eff;

    // Bypassed view (clear applied), next state (set wins over clear) and reads.
    always_comb begin
        busy_eff   = busy_q;
        busy_d     = busy_q;
        o_rs1_busy = 1'b0;
        o_rs2_busy = 1'b0;
        o_rd_busy  = 1'b0;

        for (int unsigned i = 0; i < NREG; i++) begin
            if (i_clr_valid && (i_clr_idx == RIDX_W'(i))) begin
                busy_eff[i] = 1'b0;
            end
        end
        busy_eff[0] = 1'b0;

        busy_d = busy_eff;
        for (int unsigned i = 1; i < NREG; i++) begin
            if (i_set_valid && (i_set_idx == RIDX_W'(i))) begin
                busy_d[i] = 1'b1;
            end
        end
        busy_d[0] = 1'b0;

        for (int unsigned i = 1; i < NREG; i++) begin
            if (i_rs1_idx == RIDX_W'(i)) o_rs1_busy = busy_eff[i];
            if (i_rs2_idx == RIDX_W'(i)) o_rs2_busy = busy_eff[i];
            if (i_rd_idx  == RIDX_W'(i)) o_rd_busy  = busy_eff[i];
        end
    end

    // Busy-bit register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign o_busy = busy_q;

endmodule

// File: rtl/decode_issue_ctrl.sv
// Issue controller in front of decode: instruction FIFO, hazard-gated
// single issue per cycle, and a one-cycle flush state on redirect.
module decode_issue_ctrl
    import decode_issue_ctrl_pkg::*;
#(
    parameter int unsigned QDEPTH = 2,
    parameter int unsigned NREG   = 32
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_fetch_valid,
    input  logic [XLEN-1:0]   i_fetch_instr,
    output logic              o_fetch_ready,
    output logic [XLEN-1:0]   o_dec_instr,
    input  logic [RIDX_W-1:0] i_drd,
    input  logic [RIDX_W-1:0] i_drs1,
    input  logic [RIDX_W-1:0] i_drs2,
    input  logic              i_wen,
    output logic              o_issue_valid,
    input  logic              i_issue_ready,
    input  logic              i_wb_valid,
    input  logic [RIDX_W-1:0] i_wb_rd,
    input  logic              i_flush,
    output logic              o_stall,
    output logic [NREG-1:0]   o_busy
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    state_e              state_q, state_d;
    logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [XLEN-1:0]     mem_q [QDEPTH];

    dec_regs_t           dec_regs;
    logic                in_run;
    logic                q_empty;
    logic                q_full;
    logic                push;
    logic                pop;
    logic                rs1_busy, rs2_busy, rd_busy;
    logic                haz_raw, haz_waw;
    logic                sb_set;

    assign dec_regs = '{rd: i_drd, rs1: i_drs1, rs2: i_drs2, wen: i_wen};

    // Queue status and handshakes; ready depends only on registered state.
    assign in_run        = (state_q == ST_RUN);
    assign q_empty       = (cnt_q == '0);
    assign q_full        = (cnt_q == CNT_W'(QDEPTH));
    assign o_fetch_ready = !q_full && in_run;
    assign push          = i_fetch_valid && o_fetch_ready && !i_flush;

    // Hazard detection on the head instruction.
    assign haz_raw       = rs1_busy || rs2_busy;
    assign haz_waw       = dec_regs.wen && rd_busy;
    assign o_issue_valid = !q_empty && !haz_raw && !haz_waw && !i_flush && in_run;
    assign o_stall       = !q_empty && (haz_raw || haz_waw) && in_run;
    assign pop           = o_issue_valid && i_issue_ready;
    assign sb_set        = pop && dec_regs.wen && (dec_regs.rd != '0);

    assign o_dec_instr   = q_empty ? '0 : mem_q[rd_ptr_q];

    // Next state for the FSM, FIFO pointers and occupancy.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            ST_RUN: begin
                if (i_flush) begin
                    state_d  = ST_FLUSH;
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    cnt_d    = '0;
                end else begin
                    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
                    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
                    if (push && !pop) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else if (!push && pop) begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
            end
            ST_FLUSH: begin
                wr_ptr_d = '0;
                rd_ptr_d = '0;
                cnt_d    = '0;
                if (!i_flush) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Control state register.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q  <= ST_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Instruction storage; contents are only meaningful under cnt_q.
    always_ff @(posedge i_clk) begin
        if (i_rst_n && push) begin
            mem_q[wr_ptr_q] <= i_fetch_instr;
        end
    end

    decode_issue_ctrl_scoreboard #(
        .NREG (NREG)
    ) u_scoreboard (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_set_valid (sb_set),
        .i_set_idx   (dec_regs.rd),
        .i_clr_valid (i_wb_valid),
        .i_clr_idx   (i_wb_rd),
        .i_rs1_idx   (dec_regs.rs1),
        .i_rs2_idx   (dec_regs.rs2),
        .i_rd_idx    (dec_regs.rd),
        .o_rs1_busy  (rs1_busy),
        .o_rs2_busy  (rs2_busy),
        .o_rd_busy   (rd_busy),
        .o_busy      (o_busy)
    );

endmodule

// File: tb/tb_decode_issue_ctrl.sv
// Directed bench for decode_issue_ctrl with an issue scoreboard queue.
module tb_decode_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        fetch_valid = 1'b0;
    logic [31:0] fetch_instr = '0;
    logic        fetch_ready;
    logic [31:0] dec_instr;
    logic [4:0]  drd, drs1, drs2;
    logic        wen;
    logic        issue_valid;
    logic        issue_ready = 1'b0;
    logic        wb_valid = 1'b0;
    logic [4:0]  wb_rd = '0;
    logic        flush = 1'b0;
    logic        stall;
    logic [31:0] busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    decode_issue_ctrl #(
        .QDEPTH (2),
        .NREG   (32)
    ) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_fetch_valid (fetch_valid),
        .i_fetch_instr (fetch_instr),
        .o_fetch_ready (fetch_ready),
        .o_dec_instr   (dec_instr),
        .i_drd         (drd),
        .i_drs1        (drs1),
        .i_drs2        (drs2),
        .i_wen         (wen),
        .o_issue_valid (issue_valid),
        .i_issue_ready (issue_ready),
        .i_wb_valid    (wb_valid),
        .i_wb_rd       (wb_rd),
        .i_flush       (flush),
        .o_stall       (stall),
        .o_busy        (busy)
    );

    // Minimal decoder: R-type OP opcode writes rd; the empty word decodes to nothing.
    always_comb begin
        wen  = (dec_instr[6:0] == 7'h33);
        drd  = dec_instr[11:7];
        drs1 = dec_instr[19:15];
        drs2 = dec_instr[24:20];
    end

    function automatic logic [31:0] add_w(input logic [4:0] rd, input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b000, rd, 7'h33};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic offer(input logic [31:0] w);
        fetch_valid = 1'b1;
        fetch_instr = w;
        exp_q.push_back(w);
    endtask

    // Monitor: every issue handshake must present the next expected word.
    always @(negedge clk) begin
        if (rst_n && issue_valid && issue_ready) begin
            if (exp_q.size() == 0) begin
                chk("issue_unexpected", dec_instr, 32'hFFFF_FFFF);
            end else begin
                chk("issue_word", dec_instr, exp_q.pop_front());
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values
        tick();
        tick();
        rst_n = 1'b1;
        #2;
        chk("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        chk("rst_dec_instr",   dec_instr, 32'd0);
        chk("rst_issue_valid", 32'(issue_valid), 32'd0);
        chk("rst_stall",       32'(stall), 32'd0);
        chk("rst_busy",        busy, 32'd0);

        // Stream of four independent writes, one issue per cycle
        issue_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            if (i > 1) tick();
            offer(add_w(5'(i), 5'd0, 5'd0));
            #2;
            if (i > 1) chk("stream_valid", 32'(issue_valid), 32'd1);
        end
        tick();
        fetch_valid = 1'b0;
        #2;
        chk("stream_valid_last", 32'(issue_valid), 32'd1);
        tick();
        #2;
        chk("stream_busy", busy, 32'h0000_001E);
        chk("stream_drained", 32'(issue_valid), 32'd0);
        for (int i = 1; i <= 4; i++) begin
            wb_valid = 1'b1;
            wb_rd = 5'(i);
            tick();
        end
        wb_valid = 1'b0;
        #2;
        chk("wb_clear_busy", busy, 32'd0);

        // RAW: consumer of x5 stalls until the x5 writeback bypass
        offer(add_w(5'd5, 5'd0, 5'd0));
        tick();
        offer(add_w(5'd6, 5'd5, 5'd0));
        tick();
        fetch_valid = 1'b0;
        #2;
        chk("raw_stall",       32'(stall), 32'd1);
        chk("raw_valid",       32'(issue_valid), 32'd0);
        chk("raw_busy",        busy, 32'h0000_0020);
        tick();
        #2;
        chk("raw_stall_hold",  32'(stall), 32'd1);
        wb_valid = 1'b1;
        wb_rd = 5'd5;
        #1;
        chk("raw_bypass_valid", 32'(issue_valid), 32'd1);
        chk("raw_bypass_stall", 32'(stall), 32'd0);
        tick();
        wb_valid = 1'b0;
        #2;
        chk("raw_busy_after",  busy, 32'h0000_0040);
        wb_valid = 1'b1;
        wb_rd = 5'd6;
        tick();
        wb_valid = 1'b0;

        // WAW on x7; clear and set of x7 in the same cycle leaves it busy
        offer(add_w(5'd7, 5'd0, 5'd0));
        tick();
        offer(add_w(5'd7, 5'd1, 5'd0));
        tick();
        fetch_valid = 1'b0;
        #2;
        chk("waw_stall",       32'(stall), 32'd1);
        chk("waw_busy",        busy, 32'h0000_0080);
        tick();
        #2;
        chk("waw_stall_hold",  32'(stall), 32'd1);
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        #1;
        chk("waw_bypass_valid", 32'(issue_valid), 32'd1);
        tick();
        wb_valid = 1'b0;
        #2;
        chk("waw_set_wins",    busy, 32'h0000_0080);
        wb_valid = 1'b1;
        wb_rd = 5'd7;
        tick();
        wb_valid = 1'b0;
        #2;
        chk("waw_cleared",     busy, 32'd0);

        // Full queue, then push/pop streaming across pointer wrap
        issue_ready = 1'b0;
        offer(add_w(5'd0, 5'd8, 5'd0));
        tick();
        offer(add_w(5'd0, 5'd9, 5'd0));
        #2;
        chk("full_ready_one",  32'(fetch_ready), 32'd1);
        tick();
        fetch_instr = add_w(5'd0, 5'd10, 5'd0);
        #2;
        chk("full_ready_drop", 32'(fetch_ready), 32'd0);
        chk("full_valid",      32'(issue_valid), 32'd1);
        chk("full_head",       dec_instr, add_w(5'd0, 5'd8, 5'd0));
        tick();
        #2;
        chk("full_head_hold",  dec_instr, add_w(5'd0, 5'd8, 5'd0));
        fetch_valid = 1'b0;
        issue_ready = 1'b1;
        tick();
        offer(add_w(5'd0, 5'd10, 5'd0));
        #2;
        chk("wrap_ready",      32'(fetch_ready), 32'd1);
        tick();
        offer(add_w(5'd0, 5'd11, 5'd0));
        tick();
        fetch_valid = 1'b0;
        #2;
        chk("wrap_head",       dec_instr, add_w(5'd0, 5'd11, 5'd0));
        tick();
        #2;
        chk("wrap_drained",    dec_instr, 32'd0);
        chk("wrap_valid",      32'(issue_valid), 32'd0);

        // Flush with two words queued; scoreboard is untouched
        offer(add_w(5'd3, 5'd0, 5'd0));
        tick();
        fetch_valid = 1'b0;
        tick();
        issue_ready = 1'b0;
        #2;
        chk("pre_flush_busy",  busy, 32'h0000_0008);
        offer(add_w(5'd0, 5'd12, 5'd0));
        tick();
        offer(add_w(5'd0, 5'd13, 5'd0));
        tick();
        fetch_valid = 1'b0;
        flush = 1'b1;
        #2;
        chk("flush_valid_mask", 32'(issue_valid), 32'd0);
        tick();
        flush = 1'b0;
        exp_q.delete();
        #2;
        chk("flush_dec",       dec_instr, 32'd0);
        chk("flush_ready",     32'(fetch_ready), 32'd0);
        chk("flush_valid",     32'(issue_valid), 32'd0);
        chk("flush_busy",      busy, 32'h0000_0008);
        tick();
        #2;
        chk("flush_resume",    32'(fetch_ready), 32'd1);
        offer(add_w(5'd0, 5'd14, 5'd0));
        issue_ready = 1'b1;
        tick();
        fetch_valid = 1'b0;
        #2;
        chk("post_flush_valid", 32'(issue_valid), 32'd1);
        tick();
        #2;
        chk("post_flush_busy", busy, 32'h0000_0008);
        chk("post_flush_exp",  32'(exp_q.size()), 32'd0);

        // Reset while the queue is full and the scoreboard is non-zero
        issue_ready = 1'b0;
        offer(add_w(5'd0, 5'd15, 5'd0));
        tick();
        offer(add_w(5'd0, 5'd16, 5'd0));
        tick();
        #2;
        chk("mid_full",        32'(fetch_ready), 32'd0);
        chk("mid_busy",        busy, 32'h0000_0008);
        rst_n = 1'b0;
        issue_ready = 1'b1;
        tick();
        exp_q.delete();
        fetch_valid = 1'b0;
        issue_ready = 1'b0;
        #2;
        chk("mid_rst_ready",   32'(fetch_ready), 32'd1);
        chk("mid_rst_dec",     dec_instr, 32'd0);
        chk("mid_rst_valid",   32'(issue_valid), 32'd0);
        chk("mid_rst_stall",   32'(stall), 32'd0);
        chk("mid_rst_busy",    busy, 32'd0);
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
